// File: rtl/sort_unloader_if.sv
// Handshake bundle between the sorting network, sort_unloader and the word consumer.
// slave = sort_unloader side; master = the environment driving the sorter and consuming words.
interface sort_unloader_if #(
    parameter int WIDTH = 16
);
    logic             grp_valid;
    logic [WIDTH-1:0] sorted1;
    logic [WIDTH-1:0] sorted2;
    logic [WIDTH-1:0] sorted3;
    logic [WIDTH-1:0] sorted4;
    logic [WIDTH-1:0] sorted5;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_last;
    logic             ovf;
    logic             ovf_clr;

    modport master (
        output grp_valid, sorted1, sorted2, sorted3, sorted4, sorted5, dout_ready, ovf_clr,
        input  dout, dout_valid, dout_last, ovf
    );

    modport slave (
        input  grp_valid, sorted1, sorted2, sorted3, sorted4, sorted5, dout_ready, ovf_clr,
        output dout, dout_valid, dout_last, ovf
    );
endinterface

// File: rtl/sort_unloader.sv
// Captures sorted 5-word groups LATENCY cycles after grp_valid and streams them one word per transfer.
// Latency: first word valid 1 cycle after capture; backpressure: dout_ready low holds the word, full buffer drops groups (sticky ovf).
// Optional build macro SORT_UNLOAD_ASCENDING_EN emits smallest-first instead of largest-first.
module sort_unloader #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 6,
    parameter int DEPTH   = 2
) (
    input logic          clk,
    input logic          rst,
    sort_unloader_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [LATENCY-1:0] dly;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_nxt;
    logic [2:0]         idx;
    logic [2:0]         sel;
    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic               ovf_q;
    logic               cap;
    logic               vld;
    logic               xfer;
    logic               pop;
    logic               wr_en;
    logic               drop;
    logic [WIDTH-1:0]   mem [DEPTH][5];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The sorter carries no valid, so its pipeline depth is mirrored here.
    assign cap   = dly[LATENCY-1];
    assign vld   = (state == EMIT);
    assign xfer  = vld & bus.dout_ready;
    assign pop   = xfer & (idx == 3'd4);
    assign wr_en = cap & ((count < CW'(DEPTH)) | pop);
    assign drop  = cap & ~wr_en;

    always_comb begin
        count_nxt = count;
        if (wr_en && !pop)
            count_nxt = count + 1'b1;
        else if (!wr_en && pop)
            count_nxt = count - 1'b1;
        state_nxt = (count_nxt != '0) ? EMIT : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            idx    <= '0;
            state  <= IDLE;
            ovf_q  <= 1'b0;
        end else begin
            dly   <= LATENCY'({dly, bus.grp_valid});
            count <= count_nxt;
            state <= state_nxt;
            if (wr_en)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (xfer)
                idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
            // A drop in the same cycle as a clear must still be reported.
            if (drop)
                ovf_q <= 1'b1;
            else if (bus.ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr][0] <= bus.sorted1;
            mem[wr_ptr][1] <= bus.sorted2;
            mem[wr_ptr][2] <= bus.sorted3;
            mem[wr_ptr][3] <= bus.sorted4;
            mem[wr_ptr][4] <= bus.sorted5;
        end
    end

`ifdef SORT_UNLOAD_ASCENDING_EN
    assign sel = 3'd4 - idx;
`else
    assign sel = idx;
`endif

    assign bus.dout       = vld ? mem[rd_ptr][sel] : '0;
    assign bus.dout_valid = vld;
    assign bus.dout_last  = vld & (idx == 3'd4);
    assign bus.ovf        = ovf_q;
endmodule
